// File: rtl/rot_undo_reg_if.sv
// Command/status bundle for the undoable rotator: the controller drives commands and load data,
// and the rotator returns its registered value, offset and undo status.
interface rot_undo_reg_if #(
    parameter int WIDTH = 4,
    parameter int OFF_W = 2
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             step;
    logic             direction;
    logic             undo;
    logic [WIDTH-1:0] q;
    logic [OFF_W-1:0] offset;
    logic             busy;
    logic             done;

    modport master (
        output load, din, step, direction, undo,
        input  q, offset, busy, done
    );

    modport slave (
        input  load, din, step, direction, undo,
        output q, offset, busy, done
    );
endinterface

// File: rtl/rot_undo_reg.sv
// Registered single-position rotator that tracks the net left-rotation offset and can
// walk back to the as-loaded orientation by the shortest path on an undo command.
module rot_undo_reg #(
    parameter int WIDTH = 4,
    parameter int OFF_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    rot_undo_reg_if.slave bus
);
    typedef enum logic {S_IDLE, S_UNDO} state_t;

    localparam logic [OFF_W:0]   HALF = (OFF_W+1)'(WIDTH/2);
    localparam logic [OFF_W-1:0] ONE  = OFF_W'(1);

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_q, w_q, w_rol, w_ror;
    logic [OFF_W-1:0] r_off, w_off;
    logic             r_udir, w_udir;   // 1: undo walks left, 0: undo walks right
    logic             r_busy, w_busy;
    logic             r_done, w_done;

    assign w_rol = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_ror = {r_q[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_off   <= '0;
            r_udir  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_q     <= w_q;
            r_off   <= w_off;
            r_udir  <= w_udir;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_q     = r_q;
        w_off   = r_off;
        w_udir  = r_udir;
        w_busy  = r_busy;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load) begin
                    w_q   = bus.din;
                    w_off = '0;
                end else if (bus.undo) begin
                    if (r_off == '0) begin
                        w_done = 1'b1;
                    end else begin
                        // Ties at WIDTH/2 resolve to the right-hand walk.
                        w_udir  = ({1'b0, r_off} > HALF);
                        w_busy  = 1'b1;
                        w_state = S_UNDO;
                    end
                end else if (bus.step) begin
                    if (bus.direction) begin
                        w_q   = w_rol;
                        w_off = r_off + ONE;
                    end else begin
                        w_q   = w_ror;
                        w_off = r_off - ONE;
                    end
                end
            end
            S_UNDO: begin
                if (bus.load) begin
                    w_q     = bus.din;
                    w_off   = '0;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    if (r_udir) begin
                        w_q   = w_rol;
                        w_off = r_off + ONE;
                    end else begin
                        w_q   = w_ror;
                        w_off = r_off - ONE;
                    end
                    if (w_off == '0) begin
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_state = S_IDLE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.q      = r_q;
    assign bus.offset = r_off;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_rot_undo_reg.sv
// Self-checking bench for rot_undo_reg: directed scenarios plus random command streams
// compared against a model that keeps the loaded word and the net rotation count.
module tb_rot_undo_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [3:0] m_data = '0;
    int         m_off  = 0;

    rot_undo_reg_if #(.WIDTH(4), .OFF_W(2)) bus();
    rot_undo_reg #(.WIDTH(4), .OFF_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [3:0] rotl(input logic [3:0] d, input int n);
        logic [3:0] r;
        r = d;
        for (int i = 0; i < (n % 4); i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load = 0; bus.din = '0; bus.step = 0; bus.direction = 0; bus.undo = 0;
    endtask

    task automatic do_load(input logic [3:0] d);
        bus.load = 1; bus.din = d;
        tick();
        bus.load = 0;
        m_data = d; m_off = 0;
        checks++; if (bus.q !== d) begin errors++; $display("FAIL load_q got=%b exp=%b", bus.q, d); end
        checks++; if (bus.offset !== 2'd0) begin errors++; $display("FAIL load_off got=%0d exp=0", bus.offset); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL load_flags busy=%b done=%b exp=0,0", bus.busy, bus.done); end
    endtask

    task automatic do_step(input logic dir);
        bus.step = 1; bus.direction = dir;
        tick();
        bus.step = 0;
        m_off = dir ? (m_off + 1) % 4 : (m_off + 3) % 4;
        checks++; if (bus.q !== rotl(m_data, m_off)) begin errors++; $display("FAIL step_q got=%b exp=%b", bus.q, rotl(m_data, m_off)); end
        checks++; if (bus.offset !== 2'(m_off)) begin errors++; $display("FAIL step_off got=%0d exp=%0d", bus.offset, m_off); end
    endtask

    task automatic do_undo();
        int  k, lat;
        bit  dirl, seen;
        k    = (m_off <= 2) ? m_off : 4 - m_off;
        dirl = (m_off > 2);
        bus.undo = 1;
        tick();
        bus.undo = 0;
        lat = 1;
        if (m_off == 0) begin
            checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL undo0_flags done=%b busy=%b exp=1,0", bus.done, bus.busy); end
            checks++; if (bus.q !== m_data) begin errors++; $display("FAIL undo0_q got=%b exp=%b", bus.q, m_data); end
            tick();
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL undo0_pulse done=%b exp=0", bus.done); end
            return;
        end
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL undo_start busy=%b done=%b exp=1,0", bus.busy, bus.done); end
        checks++; if (bus.q !== rotl(m_data, m_off)) begin errors++; $display("FAIL undo_start_q got=%b exp=%b", bus.q, rotl(m_data, m_off)); end
        seen = 0;
        while (!seen && lat < 8) begin
            tick();
            lat++;
            m_off = dirl ? (m_off + 1) % 4 : (m_off + 3) % 4;
            checks++; if (bus.q !== rotl(m_data, m_off)) begin errors++; $display("FAIL undo_q got=%b exp=%b", bus.q, rotl(m_data, m_off)); end
            checks++; if (bus.offset !== 2'(m_off)) begin errors++; $display("FAIL undo_off got=%0d exp=%0d", bus.offset, m_off); end
            if (bus.done === 1'b1) seen = 1;
        end
        checks++; if (!seen || lat != 1 + k) begin errors++; $display("FAIL undo_latency got=%0d exp=%0d seen=%0b", lat, 1 + k, seen); end
        checks++; if (bus.busy !== 1'b0 || m_off != 0) begin errors++; $display("FAIL undo_end busy=%b model_off=%0d exp=0,0", bus.busy, m_off); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL undo_pulse done=%b exp=0", bus.done); end
        m_off = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        rst = 0;
        m_data = '0; m_off = 0;
        checks++; if (bus.q !== 4'b0000 || bus.offset !== 2'd0) begin errors++; $display("FAIL reset_data q=%b off=%0d exp=0000,0", bus.q, bus.offset); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b exp=0,0", bus.busy, bus.done); end
        do_load(4'b1000);
    endtask

    task automatic test_short_undo();
        do_load(4'b1000);
        do_step(1); do_step(1); do_step(1);
        checks++; if (bus.q !== 4'b0100) begin errors++; $display("FAIL step3_q got=%b exp=0100", bus.q); end
        do_undo();
        checks++; if (bus.q !== 4'b1000) begin errors++; $display("FAIL short_undo_q got=%b exp=1000", bus.q); end
    endtask

    task automatic test_tie();
        do_load(4'b0011);
        do_step(1); do_step(1);
        checks++; if (bus.q !== 4'b1100) begin errors++; $display("FAIL tie_pre got=%b exp=1100", bus.q); end
        do_undo();
        checks++; if (bus.q !== 4'b0011) begin errors++; $display("FAIL tie_q got=%b exp=0011", bus.q); end
    endtask

    task automatic test_wrap_and_zero();
        do_load(4'b0001);
        do_step(0);
        checks++; if (bus.q !== 4'b1000 || bus.offset !== 2'd3) begin errors++; $display("FAIL wrap q=%b off=%0d exp=1000,3", bus.q, bus.offset); end
        do_undo();
        checks++; if (bus.q !== 4'b0001) begin errors++; $display("FAIL wrap_undo got=%b exp=0001", bus.q); end
        do_undo();
    endtask

    task automatic test_ignore_and_abort();
        do_load(4'b0001);
        do_step(1); do_step(1);
        bus.undo = 1; tick(); bus.undo = 0;
        bus.step = 1; bus.direction = 1; bus.undo = 1;
        tick();
        bus.step = 0; bus.undo = 0;
        checks++; if (bus.q !== 4'b0010 || bus.offset !== 2'd1 || bus.busy !== 1'b1) begin errors++; $display("FAIL ignore q=%b off=%0d busy=%b exp=0010,1,1", bus.q, bus.offset, bus.busy); end
        bus.load = 1; bus.din = 4'b0101;
        tick();
        bus.load = 0;
        m_data = 4'b0101; m_off = 0;
        checks++; if (bus.q !== 4'b0101 || bus.offset !== 2'd0) begin errors++; $display("FAIL abort_data q=%b off=%0d exp=0101,0", bus.q, bus.offset); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_flags busy=%b done=%b exp=0,0", bus.busy, bus.done); end
        tick();
        checks++; if (bus.done !== 1'b0 || bus.q !== 4'b0101) begin errors++; $display("FAIL abort_after done=%b q=%b exp=0,0101", bus.done, bus.q); end
    endtask

    task automatic test_reset_mid_undo();
        do_load(4'b0110);
        do_step(1); do_step(1);
        bus.undo = 1; tick(); bus.undo = 0;
        rst = 1;
        tick();
        checks++; if (bus.q !== 4'b0000 || bus.offset !== 2'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL rst_mid q=%b off=%0d busy=%b done=%b exp=0000,0,0,0", bus.q, bus.offset, bus.busy, bus.done); end
        bus.load = 1; bus.din = 4'b1111;
        tick();
        bus.load = 0; rst = 0;
        checks++; if (bus.q !== 4'b0000 || bus.offset !== 2'd0) begin errors++; $display("FAIL rst_load q=%b off=%0d exp=0000,0", bus.q, bus.offset); end
        tick();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 4'b0000) begin errors++; $display("FAIL rst_after done=%b busy=%b q=%b exp=0,0,0000", bus.done, bus.busy, bus.q); end
        m_data = '0; m_off = 0;
    endtask

    task automatic test_random();
        int r;
        do_load(4'($urandom));
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) do_load(4'($urandom));
            else if (r < 7) do_step(1'($urandom));
            else if (r < 9) do_undo();
            else begin
                tick();
                checks++; if (bus.q !== rotl(m_data, m_off) || bus.offset !== 2'(m_off) || bus.done !== 1'b0) begin
                    errors++; $display("FAIL hold q=%b off=%0d done=%b exp=%b,%0d,0", bus.q, bus.offset, bus.done, rotl(m_data, m_off), m_off); end
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_short_undo();
        test_tie();
        test_wrap_and_zero();
        test_ignore_and_abort();
        test_reset_mid_undo();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
